// File: rtl/avalon_pio_poller.sv
// Avalon-MM read master polling an input PIO register and emitting change events.
// Define PIO_POLLER_DEBOUNCE_EN to require two matching polls before an event.
module avalon_pio_poller #(
    parameter int DATA_W   = 32,
    parameter int POLL_DIV = 1024,
    parameter int PIO_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [DATA_W-1:0] evt_prev
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(POLL_DIV - 1);

    logic [1:0]        r_state;
    logic [15:0]       r_cnt;
    logic              r_read;
    logic              r_valid;
    logic [DATA_W-1:0] r_sample;
    logic [DATA_W-1:0] r_last;

    logic w_poll_due;
    logic w_accept;
    logic w_handshake;
    logic w_changed;

    assign w_poll_due  = enable && (r_cnt == DIV_LAST);
    assign w_accept    = r_read && !avm_waitrequest;
    assign w_handshake = r_valid && evt_ready;

`ifdef PIO_POLLER_DEBOUNCE_EN
    logic [DATA_W-1:0] r_cand;

    // A new value must be seen on two consecutive polls before it is reported
    assign w_changed = (avm_readdata != r_last) && (avm_readdata == r_cand);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_cand <= avm_readdata;
        end
    end
`else
    assign w_changed = (avm_readdata != r_last);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_read   <= 1'b0;
            r_valid  <= 1'b0;
            r_sample <= '0;
            r_last   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!enable) begin
                        r_cnt <= '0;
                    end else if (w_poll_due) begin
                        r_cnt   <= '0;
                        r_read  <= 1'b1;
                        r_state <= S_READ;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_READ: begin
                    // The read is held until the slave accepts it
                    if (w_accept) begin
                        r_read  <= 1'b0;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_sample <= avm_readdata;
                    if (w_changed) begin
                        r_valid <= 1'b1;
                        r_state <= S_EMIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        r_last  <= r_sample;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign avm_address = 2'(PIO_ADDR);
    assign avm_read    = r_read;
    assign evt_valid   = r_valid;
    assign evt_data    = r_sample;
    assign evt_prev    = r_last;

endmodule
